// File: rtl/memristor_crossbar_engine_if.sv
// Command/response bundle for the memristor crossbar engine.
// The command source drives through the master modport; the engine uses slave.
interface memristor_crossbar_engine_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RW = $clog2(ROWS);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [RW-1:0]   cmd_dst;
  logic [RW-1:0]   cmd_src_a;
  logic [RW-1:0]   cmd_src_b;
  logic [COLS-1:0] cmd_mask;
  logic [COLS-1:0] cmd_data;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_mask, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_mask, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/memristor_crossbar_engine.sv
// Row-parallel stateful-logic crossbar: ROWS x COLS single-bit cells updated
// one destination row per step under a column mask. NOT and NAND are
// sequenced as CLEAR followed by one or two IMPLY steps.
module memristor_crossbar_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  memristor_crossbar_engine_if.slave bus,
  output logic                     busy,
  output logic [ROWS*COLS-1:0]     q
);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLEAR = 3'd1,
    OP_SET   = 3'd2,
    OP_WRITE = 3'd3,
    OP_IMPLY = 3'd4,
    OP_NAND  = 3'd5,
    OP_READ  = 3'd6,
    OP_NOT   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S2   = 2'd1,
    S3   = 2'd2
  } state_e;

  state_e          state, state_next;
  logic [ROWS*COLS-1:0] cells;

  op_e             op_q;
  logic [RW-1:0]   dst_q, a_q, b_q;
  logic [COLS-1:0] mask_q;

  op_e             cmd_op;
  logic            accept;

  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_val;
  logic [COLS-1:0] wr_mask;

  // Rows at or beyond ROWS (non-power-of-2 sizes) read as all-zero.
  function automatic logic [COLS-1:0] row_of(input logic [ROWS*COLS-1:0] arr,
                                             input logic [RW-1:0] idx);
    row_of = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (RW'(r) == idx) row_of = arr[r*COLS +: COLS];
    end
  endfunction

  assign cmd_op        = op_e'(bus.cmd_op);
  assign bus.cmd_ready = (state == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign busy          = (state != IDLE);
  assign q             = cells;

  // Next state and the single row write performed at this edge.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_row     = bus.cmd_dst;
    wr_val     = '0;
    wr_mask    = bus.cmd_mask;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: begin
              wr_en  = 1'b1;
              wr_val = '0;
            end
            OP_SET: begin
              wr_en  = 1'b1;
              wr_val = '1;
            end
            OP_WRITE: begin
              wr_en  = 1'b1;
              wr_val = bus.cmd_data;
            end
            OP_IMPLY: begin
              wr_en  = 1'b1;
              wr_val = ~row_of(cells, bus.cmd_src_a) | row_of(cells, bus.cmd_dst);
            end
            OP_NOT, OP_NAND: begin
              wr_en      = 1'b1;
              wr_val     = '0;
              state_next = S2;
            end
            default: ;
          endcase
        end
      end
      S2: begin
        wr_en      = 1'b1;
        wr_row     = dst_q;
        wr_mask    = mask_q;
        wr_val     = ~row_of(cells, a_q) | row_of(cells, dst_q);
        state_next = (op_q == OP_NAND) ? S3 : IDLE;
      end
      S3: begin
        wr_en      = 1'b1;
        wr_row     = dst_q;
        wr_mask    = mask_q;
        wr_val     = ~row_of(cells, b_q) | row_of(cells, dst_q);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Operands captured at accept for the later steps of NOT/NAND.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_NOP;
      dst_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mask_q <= '0;
    end else if (accept) begin
      op_q   <= cmd_op;
      dst_q  <= bus.cmd_dst;
      a_q    <= bus.cmd_src_a;
      b_q    <= bus.cmd_src_b;
      mask_q <= bus.cmd_mask;
    end
  end

  // Crossbar array: masked parallel update of the addressed row only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cells <= '0;
    end else if (wr_en) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (RW'(r) == wr_row)
          cells[r*COLS +: COLS] <= (cells[r*COLS +: COLS] & ~wr_mask) | (wr_val & wr_mask);
      end
    end
  end

  // Registered READ response: one-cycle valid, data held until next READ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= accept && (cmd_op == OP_READ);
      if (accept && (cmd_op == OP_READ))
        bus.rsp_data <= row_of(cells, bus.cmd_src_a);
    end
  end
endmodule

// File: tb/tb_memristor_crossbar_engine.sv
// Bench for memristor_crossbar_engine: an 8-row and a 6-row instance receive
// identical commands; both are compared against a row-array reference model.
module tb_memristor_crossbar_engine;
  logic clock;
  logic reset_n;

  logic       valid;
  logic [2:0] op, dst, src_a, src_b;
  logic [7:0] mask, data;

  logic        busy8, busy6;
  logic [63:0] q8;
  logic [47:0] q6;

  memristor_crossbar_engine_if #(.ROWS(8), .COLS(8)) bus8();
  memristor_crossbar_engine_if #(.ROWS(6), .COLS(8)) bus6();

  assign bus8.cmd_valid = valid;
  assign bus8.cmd_op    = op;
  assign bus8.cmd_dst   = dst;
  assign bus8.cmd_src_a = src_a;
  assign bus8.cmd_src_b = src_b;
  assign bus8.cmd_mask  = mask;
  assign bus8.cmd_data  = data;
  assign bus6.cmd_valid = valid;
  assign bus6.cmd_op    = op;
  assign bus6.cmd_dst   = dst;
  assign bus6.cmd_src_a = src_a;
  assign bus6.cmd_src_b = src_b;
  assign bus6.cmd_mask  = mask;
  assign bus6.cmd_data  = data;

  memristor_crossbar_engine #(.ROWS(8), .COLS(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .bus(bus8), .busy(busy8), .q(q8)
  );
  memristor_crossbar_engine #(.ROWS(6), .COLS(8)) dut6 (
    .clock(clock), .reset_n(reset_n), .bus(bus6), .busy(busy6), .q(q6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m8, m6;     // reference arrays, row r at bits r*8+:8
  logic [7:0]  e8, e6;     // expected READ data
  time         acc_time;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [63:0] m, input int nr, input int i);
    return (i < nr) ? m[i*8 +: 8] : 8'h00;
  endfunction

  function automatic logic [63:0] wr(input logic [63:0] m, input int nr, input int i,
                                     input logic [7:0] v, input logic [7:0] mk);
    if (i < nr) m[i*8 +: 8] = (m[i*8 +: 8] & ~mk) | (v & mk);
    return m;
  endfunction

  // Final array contents after a whole command completes.
  function automatic logic [63:0] apply(input logic [63:0] m, input int nr, input int o,
                                        input int d, input int a, input int b,
                                        input logic [7:0] mk, input logic [7:0] dt);
    case (o)
      1: m = wr(m, nr, d, 8'h00, mk);
      2: m = wr(m, nr, d, 8'hFF, mk);
      3: m = wr(m, nr, d, dt, mk);
      4: m = wr(m, nr, d, ~rd(m, nr, a) | rd(m, nr, d), mk);
      5: begin
        m = wr(m, nr, d, 8'h00, mk);
        m = wr(m, nr, d, ~rd(m, nr, a) | rd(m, nr, d), mk);
        m = wr(m, nr, d, ~rd(m, nr, b) | rd(m, nr, d), mk);
      end
      7: begin
        m = wr(m, nr, d, 8'h00, mk);
        m = wr(m, nr, d, ~rd(m, nr, a) | rd(m, nr, d), mk);
      end
      default: ;
    endcase
    return m;
  endfunction

  // Present a command at a falling edge, wait for acceptance, update the
  // model at the accept edge; returns at the following falling edge.
  task automatic send(input int o, input int d, input int a, input int b,
                      input logic [7:0] mk, input logic [7:0] dt);
    int n;
    op = 3'(o); dst = 3'(d); src_a = 3'(a); src_b = 3'(b);
    mask = mk; data = dt; valid = 1'b1;
    n = 0;
    while (!bus8.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus8.cmd_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      valid = 1'b0;
      return;
    end
    e8 = rd(m8, 8, a);
    e6 = rd(m6, 6, a);
    @(posedge clock);
    acc_time = $time;
    m8 = apply(m8, 8, o, d, a, b, mk, dt);
    m6 = apply(m6, 6, o, d, a, b, mk, dt);
    @(negedge clock);
    valid = 1'b0;
  endtask

  task automatic run_cmd(input int o, input int d, input int a, input int b,
                         input logic [7:0] mk, input logic [7:0] dt);
    int n, steps;
    steps = (o == 5) ? 2 : (o == 7) ? 1 : 0;
    send(o, d, a, b, mk, dt);
    check("rsp_valid", 64'(bus8.rsp_valid), 64'(o == 6));
    check("ready_low", 64'(bus8.cmd_ready), 64'(steps == 0));
    if (o == 6) begin
      check("rsp_data8", 64'(bus8.rsp_data), 64'(e8));
      check("rsp_data6", 64'(bus6.rsp_data), 64'(e6));
    end
    n = 0;
    while (busy8 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("busy_cycles", 64'(n), 64'(steps));
    check("busy6", 64'(busy6), 64'd0);
    check("q8", q8, m8);
    check("q6", {16'h0, q6}, m6);
    if (o == 6) begin
      @(negedge clock);
      check("rsp_pulse", 64'(bus8.rsp_valid), 64'd0);
    end
  endtask

  initial begin
    time t0;
    reset_n = 1'b0;
    valid = 1'b0;
    op = '0; dst = '0; src_a = '0; src_b = '0; mask = '0; data = '0;
    m8 = '0;
    m6 = '0;
    #2;
    check("reset_q8", q8, 64'd0);
    check("reset_q6", {16'h0, q6}, 64'd0);
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_rsp_valid", 64'(bus8.rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(bus8.rsp_data), 64'd0);
    check("reset_ready", 64'(bus8.cmd_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // WRITE then READ row 3
    run_cmd(3, 3, 0, 0, 8'hFF, 8'hA5);
    run_cmd(6, 0, 3, 0, 8'hFF, 8'h00);
    check("read_row3", 64'(bus8.rsp_data), 64'hA5);
    check("row3_only", q8, 64'h0000_0000_A500_0000);

    // NAND 0xF0, 0xCC -> 0x3F
    run_cmd(3, 0, 0, 0, 8'hFF, 8'hF0);
    run_cmd(3, 1, 0, 0, 8'hFF, 8'hCC);
    run_cmd(5, 2, 0, 1, 8'hFF, 8'h00);
    check("nand_row2", 64'(q8[23:16]), 64'h3F);
    check("nand_src", 64'(q8[15:0]), 64'hCCF0);

    // IMPLY under partial mask
    run_cmd(3, 2, 0, 0, 8'hFF, 8'h00);
    run_cmd(3, 5, 0, 0, 8'hFF, 8'h0F);
    run_cmd(4, 2, 5, 0, 8'h3C, 8'h00);
    check("imply_row2", 64'(q8[23:16]), 64'h30);

    // NOT aliased onto its own source
    run_cmd(3, 4, 0, 0, 8'hFF, 8'h55);
    run_cmd(7, 4, 4, 0, 8'h0F, 8'h00);
    check("not_alias", 64'(q8[39:32]), 64'h5F);

    // Back-to-back single-step accepts
    send(2, 6, 0, 0, 8'hFF, 8'h00);
    t0 = acc_time;
    send(1, 6, 0, 0, 8'h0F, 8'h00);
    check("b2b_spacing", 64'(acc_time - t0), 64'd10);
    check("b2b_row6", 64'(q8[55:48]), 64'hF0);
    check("b2b_q8", q8, m8);

    // Command held valid while busy is taken on the first idle edge
    send(5, 7, 0, 3, 8'hFF, 8'h00);
    t0 = acc_time;
    send(3, 0, 0, 0, 8'hFF, 8'h96);
    check("pending_spacing", 64'(acc_time - t0), 64'd30);
    check("pending_q8", q8, m8);
    check("pending_q6", {16'h0, q6}, m6);

    // Reset in the middle of a NAND
    send(5, 2, 0, 1, 8'hFF, 8'h00);
    check("mid_busy", 64'(busy8), 64'd1);
    reset_n = 1'b0;
    #1;
    m8 = '0;
    m6 = '0;
    check("abort_q8", q8, 64'd0);
    check("abort_q6", {16'h0, q6}, 64'd0);
    check("abort_busy", 64'(busy8), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_cmd(3, 1, 0, 0, 8'hFF, 8'h3C);

    // Out-of-range row on the 6-row instance
    run_cmd(3, 5, 0, 0, 8'hFF, 8'h77);
    run_cmd(3, 7, 0, 0, 8'hFF, 8'hEE);
    check("oor_write6", {16'h0, q6}, 64'h0000_7700_0000_3C00);
    run_cmd(6, 0, 7, 0, 8'hFF, 8'h00);
    check("oor_read6", 64'(bus6.rsp_data), 64'h00);
    check("oor_read8", 64'(bus8.rsp_data), 64'hEE);

    // Randomized commands
    repeat (150) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
